matmul_sched: RTL and testbench

Sequencer for the MAC datapath of the matrix multiplier. Once both operand matrices are loaded, it walks every result element C[i][j] of an N×N product. For each element it clears the MAC, drives the A/B operand mux selects for N accumulate cycles, and presents the finished accumulator to the result sink through a valid/ready handshake. It sits between the operand-load controller (which asserts `start`) and the output register/final-mux stage.

---
 rtl/matmul_sched.sv | 142 ++++++++++++++
 tb/tb_matmul_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_sched.sv
// matmul_sched: walks every C[i][j] of an N x N product.
// For each element it clears the MAC, then runs N accumulate cycles with
// the A/B mux selects. It then holds the result under a valid/ready
// handshake until the sink accepts it. Results come out in row-major order.
// Every output is decoded from registered state, so neither start nor
// res_ready has a combinational path to an output.
module matmul_sched #(
    parameter int N = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [3:0] a_sel,
    output logic [3:0] b_sel,
    output logic       mac_clr,
    output logic       mac_en,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_idx
);

    localparam logic [3:0] N4  = 4'(N);
    localparam logic [1:0] NM1 = 2'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_ACC,
        S_WB,
        S_DONE
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] i, j, k;
    logic [1:0] i_nxt, j_nxt, k_nxt;

    // State and counter registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            i     <= 2'd0;
            j     <= 2'd0;
            k     <= 2'd0;
        end else begin
            state <= state_nxt;
            i     <= i_nxt;
            j     <= j_nxt;
            k     <= k_nxt;
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        state_nxt = state;
        i_nxt     = i;
        j_nxt     = j;
        k_nxt     = k;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_CLR;
                    i_nxt     = 2'd0;
                    j_nxt     = 2'd0;
                    k_nxt     = 2'd0;
                end
            end
            S_CLR: begin
                k_nxt     = 2'd0;
                state_nxt = S_ACC;
            end
            S_ACC: begin
                // k stays at N-1 on the final accumulate cycle.
                if (k == NM1) state_nxt = S_WB;
                else          k_nxt     = k + 2'd1;
            end
            S_WB: begin
                if (res_ready) begin
                    if (i == NM1 && j == NM1) begin
                        state_nxt = S_DONE;
                    end else begin
                        if (j == NM1) begin
                            j_nxt = 2'd0;
                            i_nxt = i + 2'd1;
                        end else begin
                            j_nxt = j + 2'd1;
                        end
                        state_nxt = S_CLR;
                    end
                end
            end
            S_DONE: begin
                i_nxt     = 2'd0;
                j_nxt     = 2'd0;
                k_nxt     = 2'd0;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                i_nxt     = 2'd0;
                j_nxt     = 2'd0;
                k_nxt     = 2'd0;
            end
        endcase
    end

    // Output decode from registered state and counters only.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        a_sel     = 4'd0;
        b_sel     = 4'd0;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        res_valid = 1'b0;
        res_idx   = 4'd0;
        case (state)
            S_CLR: begin
                busy    = 1'b1;
                mac_clr = 1'b1;
            end
            S_ACC: begin
                busy   = 1'b1;
                mac_en = 1'b1;
                a_sel  = {2'b00, i} * N4 + {2'b00, k};
                b_sel  = {2'b00, k} * N4 + {2'b00, j};
            end
            S_WB: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                res_idx   = {2'b00, i} * N4 + {2'b00, j};
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_matmul_sched.sv
// Directed bench for matmul_sched: N=3 and N=2 instances share stimulus.
// Per-cycle stimulus tables drive both instances, and the outputs are
// captured each cycle. The captures are then compared against
// hand-computed vectors.
module tb_matmul_sched;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic res_ready = 1'b0;

    logic       busy3, done3, clr3, en3, valid3;
    logic [3:0] a3, b3, idx3;
    logic       busy2, done2, clr2, en2, valid2;
    logic [3:0] a2, b2, idx2;

    always #5 clk = ~clk;

    matmul_sched #(.N(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .busy(busy3), .done(done3),
        .a_sel(a3), .b_sel(b3), .mac_clr(clr3), .mac_en(en3),
        .res_valid(valid3), .res_ready(res_ready), .res_idx(idx3)
    );

    matmul_sched #(.N(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .busy(busy2), .done(done2),
        .a_sel(a2), .b_sel(b2), .mac_clr(clr2), .mac_en(en2),
        .res_valid(valid2), .res_ready(res_ready), .res_idx(idx2)
    );

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       clr;
        logic       en;
        logic       valid;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] idx;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t exp;
    } vec_t;

    localparam int MAXC = 128;

    obs_t obs3 [MAXC];
    obs_t obs2 [MAXC];
    bit   st   [MAXC];
    bit   rdy  [MAXC];
    bit   rst  [MAXC];

    vec_t t3[$];
    vec_t t2[$];

    int checks = 0;
    int failures = 0;

    function automatic obs_t mk(input logic bz, input logic dn, input logic cl,
                                input logic en, input logic vl, input int a,
                                input int b, input int idx);
        obs_t o;
        o.busy  = bz;
        o.done  = dn;
        o.clr   = cl;
        o.en    = en;
        o.valid = vl;
        o.a     = 4'(a);
        o.b     = 4'(b);
        o.idx   = 4'(idx);
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_stim();
        for (int c = 0; c < MAXC; c++) begin
            st[c]  = 1'b0;
            rdy[c] = 1'b1;
            rst[c] = 1'b0;
        end
    endtask

    // Two reset edges, then leave the bench 1ns after a rising edge.
    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        res_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Cycle c: drive inputs, sample at the falling edge, end at the rising edge.
    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            start     = st[c];
            res_ready = rdy[c];
            reset     = rst[c];
            @(negedge clk);
            obs3[c] = {busy3, done3, clr3, en3, valid3, a3, b3, idx3};
            obs2[c] = {busy2, done2, clr2, en2, valid2, a2, b2, idx2};
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic check_table3(input string tag);
        foreach (t3[v])
            chk($sformatf("%s_n3_cyc%0d", tag, t3[v].cyc), 32'(obs3[t3[v].cyc]), 32'(t3[v].exp));
    endtask

    initial begin
        int cnt;
        obs_t z;
        z = '0;

        // N=3 full-throughput vectors.
        t3.push_back('{0,  mk(0,0,0,0,0,0,0,0)});
        t3.push_back('{1,  mk(1,0,1,0,0,0,0,0)});
        t3.push_back('{2,  mk(1,0,0,1,0,0,0,0)});
        t3.push_back('{3,  mk(1,0,0,1,0,1,3,0)});
        t3.push_back('{4,  mk(1,0,0,1,0,2,6,0)});
        t3.push_back('{5,  mk(1,0,0,0,1,0,0,0)});
        t3.push_back('{6,  mk(1,0,1,0,0,0,0,0)});
        t3.push_back('{7,  mk(1,0,0,1,0,0,1,0)});
        t3.push_back('{10, mk(1,0,0,0,1,0,0,1)});
        t3.push_back('{22, mk(1,0,0,1,0,3,1,0)});
        t3.push_back('{23, mk(1,0,0,1,0,4,4,0)});
        t3.push_back('{24, mk(1,0,0,1,0,5,7,0)});
        t3.push_back('{25, mk(1,0,0,0,1,0,0,4)});
        t3.push_back('{27, mk(1,0,0,1,0,3,2,0)});
        t3.push_back('{28, mk(1,0,0,1,0,4,5,0)});
        t3.push_back('{29, mk(1,0,0,1,0,5,8,0)});
        t3.push_back('{30, mk(1,0,0,0,1,0,0,5)});
        t3.push_back('{45, mk(1,0,0,0,1,0,0,8)});
        t3.push_back('{46, mk(1,1,0,0,0,0,0,0)});
        t3.push_back('{47, mk(0,0,0,0,0,0,0,0)});

        // N=2 full-throughput vectors.
        t2.push_back('{0,  mk(0,0,0,0,0,0,0,0)});
        t2.push_back('{1,  mk(1,0,1,0,0,0,0,0)});
        t2.push_back('{2,  mk(1,0,0,1,0,0,0,0)});
        t2.push_back('{3,  mk(1,0,0,1,0,1,2,0)});
        t2.push_back('{4,  mk(1,0,0,0,1,0,0,0)});
        t2.push_back('{13, mk(1,0,1,0,0,0,0,0)});
        t2.push_back('{14, mk(1,0,0,1,0,2,1,0)});
        t2.push_back('{15, mk(1,0,0,1,0,3,3,0)});
        t2.push_back('{16, mk(1,0,0,0,1,0,0,3)});
        t2.push_back('{17, mk(1,1,0,0,0,0,0,0)});
        t2.push_back('{18, mk(0,0,0,0,0,0,0,0)});

        // Reset state, with start held high during reset.
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset_n3", 32'({busy3, done3, clr3, en3, valid3, a3, b3, idx3}), 32'(z));
        chk("reset_n2", 32'({busy2, done2, clr2, en2, valid2, a2, b2, idx2}), 32'(z));

        // Full run.
        do_reset();
        clear_stim();
        st[0] = 1'b1;
        run(52);
        check_table3("full");
        foreach (t2[v])
            chk($sformatf("full_n2_cyc%0d", t2[v].cyc), 32'(obs2[t2[v].cyc]), 32'(t2[v].exp));
        cnt = 0;
        for (int c = 0; c < 52; c++) begin
            if (obs3[c].valid) begin
                chk($sformatf("full_n3_idx_at%0d", c), 32'(obs3[c].idx), 32'(cnt));
                chk($sformatf("full_n3_wbcyc_idx%0d", cnt), 32'(c), 32'((cnt + 1) * 5));
                cnt++;
            end
            chk($sformatf("full_n3_busy%0d", c), 32'(obs3[c].busy), 32'(c >= 1 && c <= 46));
            chk($sformatf("full_n3_done%0d", c), 32'(obs3[c].done), 32'(c == 46));
        end
        chk("full_n3_nresults", 32'(cnt), 32'd9);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (obs2[c].valid) begin
                chk($sformatf("full_n2_idx_at%0d", c), 32'(obs2[c].idx), 32'(cnt));
                chk($sformatf("full_n2_wbcyc_idx%0d", cnt), 32'(c), 32'((cnt + 1) * 4));
                cnt++;
            end
        end
        chk("full_n2_nresults", 32'(cnt), 32'd4);

        // Backpressure during WB of idx 4 (first WB cycle 25).
        do_reset();
        clear_stim();
        st[0] = 1'b1;
        rdy[25] = 1'b0;
        rdy[26] = 1'b0;
        rdy[27] = 1'b0;
        run(55);
        for (int c = 25; c <= 28; c++) begin
            chk($sformatf("bp_valid%0d", c), 32'(obs3[c].valid), 32'd1);
            chk($sformatf("bp_idx%0d", c), 32'(obs3[c].idx), 32'd4);
            chk($sformatf("bp_noclr%0d", c), 32'(obs3[c].clr), 32'd0);
        end
        chk("bp_clr29", 32'(obs3[29].clr), 32'd1);
        chk("bp_idx5_at33", 32'({obs3[33].valid, obs3[33].idx}), 32'({1'b1, 4'd5}));
        for (int c = 0; c < 55; c++)
            chk($sformatf("bp_done%0d", c), 32'(obs3[c].done), 32'(c == 49));

        // Start pulses while busy are ignored.
        do_reset();
        clear_stim();
        st[0]  = 1'b1;
        st[10] = 1'b1;
        st[30] = 1'b1;
        run(52);
        check_table3("sb");
        for (int c = 0; c < 52; c++)
            chk($sformatf("sb_done%0d", c), 32'(obs3[c].done), 32'(c == 46));

        // Reset in cycle 13 (ACC of idx 2), restart in cycle 20.
        do_reset();
        clear_stim();
        st[0]  = 1'b1;
        rst[13] = 1'b1;
        st[20] = 1'b1;
        run(70);
        chk("rst_acc13", 32'({obs3[13].en, obs3[13].a, obs3[13].b}), 32'({1'b1, 4'd1, 4'd5}));
        for (int c = 14; c <= 20; c++)
            chk($sformatf("rst_idle%0d", c), 32'(obs3[c]), 32'(z));
        chk("rst_restart_clr21", 32'(obs3[21].clr), 32'd1);
        chk("rst_restart_idx0", 32'({obs3[25].valid, obs3[25].idx}), 32'({1'b1, 4'd0}));
        chk("rst_restart_idx1", 32'({obs3[30].valid, obs3[30].idx}), 32'({1'b1, 4'd1}));
        for (int c = 0; c < 70; c++)
            chk($sformatf("rst_done%0d", c), 32'(obs3[c].done), 32'(c == 66));

        // Idle: res_ready high, no start.
        do_reset();
        clear_stim();
        run(20);
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("idle_n3_%0d", c), 32'(obs3[c]), 32'(z));
            chk($sformatf("idle_n2_%0d", c), 32'(obs2[c]), 32'(z));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
